// File: rtl/fir_tdm_mac.sv
// Single-multiplier FIR filter. One multiply-accumulate is done per clock over TAPS taps,
// then the result is rounded, shifted and saturated onto a registered output.
module fir_tdm_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 6,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int ROUND  = 1,
  localparam int PTR_W = $clog2(TAPS)
) (
  input  logic              clk_30p72MHz,
  input  logic              reset,
  input  logic              nd,
  input  logic [DATA_W-1:0] din,
  output logic              rfd,
  input  logic              coef_we,
  input  logic [PTR_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_din,
  output logic              rdy,
  output logic [OUT_W-1:0]  dout,
  output logic              sat,
  output logic [1:0]        dbg_state_o
);

  // Handshake: din is taken on a rising edge where nd=1 and rfd=1; rdy is a
  // one-cycle strobe marking dout/sat as fresh, and they hold until the next rdy.

  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + PTR_W;
  localparam int RW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [PTR_W-1:0] K_LAST   = PTR_W'(TAPS - 1);
  localparam logic [PTR_W:0]   TAPS_EXT = (PTR_W + 1)'(TAPS);

  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RND_SH) : '0;
  localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic [PTR_W-1:0]         wptr_q, wptr_d;
  logic [PTR_W-1:0]         newest_q, newest_d;
  logic [PTR_W-1:0]         k_q, k_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [OUT_W-1:0]         dout_q, dout_d;
  logic                     sat_q, sat_d;
  logic                     rdy_q, rdy_d;

  logic signed [DATA_W-1:0] dline_q [TAPS];
  logic signed [COEF_W-1:0] coef_q  [TAPS];

  logic                     idle;
  logic                     accept;
  logic                     coef_ok;
  logic [PTR_W:0]           idx_wide;
  logic [PTR_W-1:0]         tap_idx;
  logic signed [PW-1:0]     prod;
  logic signed [RW-1:0]     sum_r;
  logic signed [RW-1:0]     r_sh;
  logic                     sat_hi;
  logic                     sat_lo;

  assign idle    = (state_q == S_IDLE);
  assign accept  = nd && idle;
  assign coef_ok = coef_we && idle && ({1'b0, coef_addr} < TAPS_EXT);

  // Tap k reads (newest - k) mod TAPS; the +TAPS keeps the subtraction non-negative.
  always_comb begin
    idx_wide = {1'b0, newest_q} + TAPS_EXT - {1'b0, k_q};
    if (idx_wide >= TAPS_EXT) idx_wide = idx_wide - TAPS_EXT;
    tap_idx = idx_wide[PTR_W-1:0];
  end

  assign prod = dline_q[tap_idx] * coef_q[k_q];

  assign sum_r  = {acc_q[AW-1], acc_q} + RND;
  assign r_sh   = sum_r >>> SHIFT;
  assign sat_hi = (r_sh > OMAX);
  assign sat_lo = (r_sh < OMIN);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    newest_d = newest_q;
    k_d      = k_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    sat_d    = sat_q;
    rdy_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nd) begin
          newest_d = wptr_q;
          wptr_d   = (wptr_q == K_LAST) ? '0 : wptr_q + 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + AW'(prod);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OUT: begin
        if (sat_hi)      dout_d = OMAX[OUT_W-1:0];
        else if (sat_lo) dout_d = OMIN[OUT_W-1:0];
        else             dout_d = r_sh[OUT_W-1:0];
        sat_d   = sat_hi || sat_lo;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_30p72MHz or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      newest_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      sat_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      newest_q <= newest_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      sat_q    <= sat_d;
      rdy_q    <= rdy_d;
    end
  end

  // A coefficient written on the accept edge is already in place for the first product.
  always_ff @(posedge clk_30p72MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      if (accept)  dline_q[wptr_q]  <= din;
      if (coef_ok) coef_q[coef_addr] <= coef_din;
    end
  end

  assign rfd         = idle;
  assign rdy         = rdy_q;
  assign dout        = dout_q;
  assign sat         = sat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac: impulse, rounding, saturation, handshake,
// coefficient write gating and mid-computation reset.
module tb_fir_tdm_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        nd;
  logic [15:0] din;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_din;
  logic        rfd, rdy, sat;
  logic [15:0] dout;
  logic [1:0]  dbg_state;
  logic        nr_rfd, nr_rdy, nr_sat;
  logic [15:0] nr_dout;
  logic [1:0]  nr_dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] ctab [6];

  always #5 clk = ~clk;

  fir_tdm_mac dut (
    .clk_30p72MHz(clk), .reset(rst), .nd(nd), .din(din), .rfd(rfd),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
    .rdy(rdy), .dout(dout), .sat(sat), .dbg_state_o(dbg_state)
  );

  fir_tdm_mac #(.ROUND(0)) dut_nr (
    .clk_30p72MHz(clk), .reset(rst), .nd(nd), .din(din), .rfd(nr_rfd),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
    .rdy(nr_rdy), .dout(nr_dout), .sat(nr_sat), .dbg_state_o(nr_dbg_state)
  );

  task automatic write_coef(input int a, input logic [15:0] v);
    coef_addr = 3'(a);
    coef_din  = v;
    coef_we   = 1'b1;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic load_ctab();
    for (int i = 0; i < 6; i++) write_coef(i, ctab[i]);
  endtask

  // Waits for rfd, presents one sample, then waits for rdy; lat counts edges after accept.
  task automatic run_sample(input logic [15:0] x, input bit pulse_nd, input bit pulse_we,
                            output logic [15:0] y, output logic s, output int lat);
    int g;
    g = 0;
    while (!rfd && g < 40) begin
      @(negedge clk);
      g++;
    end
    nd  = 1'b1;
    din = x;
    @(negedge clk);
    nd      = 1'b0;
    din     = 16'h0000;
    coef_we = 1'b0;
    lat     = 0;
    while (!rdy && lat < 30) begin
      if (lat == 2 && pulse_nd) begin
        nd  = 1'b1;
        din = 16'h1234;
      end
      if (lat == 2 && pulse_we) begin
        coef_addr = 3'd0;
        coef_din  = 16'd999;
        coef_we   = 1'b1;
      end
      @(negedge clk);
      nd      = 1'b0;
      coef_we = 1'b0;
      lat++;
    end
    y = dout;
    s = sat;
  endtask

  task automatic flush_zero();
    logic [15:0] y;
    logic s;
    int lat;
    for (int i = 0; i < 6; i++) run_sample(16'h0000, 1'b0, 1'b0, y, s, lat);
  endtask

  task automatic test_reset();
    total++; if (rfd !== 1'b1) begin bad++; $display("FAIL reset_rfd got=%b exp=1", rfd); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_impulse();
    logic [15:0] y, e;
    logic s;
    int lat;
    ctab = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600};
    load_ctab();
    flush_zero();
    for (int i = 0; i < 7; i++) begin
      run_sample((i == 0) ? 16'h7FFF : 16'h0000, 1'b0, 1'b0, y, s, lat);
      e = (i < 6) ? ctab[i] : 16'd0;
      total++; if (y !== e) begin bad++; $display("FAIL impulse_dout[%0d] got=%0d exp=%0d", i, y, e); end
      total++; if (s !== 1'b0) begin bad++; $display("FAIL impulse_sat[%0d] got=%b exp=0", i, s); end
      total++; if (lat !== 7) begin bad++; $display("FAIL impulse_latency[%0d] got=%0d exp=7", i, lat); end
    end
    @(negedge clk);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rdy_one_cycle got=%b exp=0", rdy); end
  endtask

  task automatic test_rounding();
    logic [15:0] xs [4];
    logic [15:0] er [4];
    logic [15:0] et [4];
    logic [15:0] y;
    logic s;
    int lat;
    xs = '{16'h4000, 16'h3FFF, 16'hC000, 16'hBFFF};
    er = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    et = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    write_coef(0, 16'd1);
    for (int i = 1; i < 6; i++) write_coef(i, 16'd0);
    for (int i = 0; i < 4; i++) begin
      run_sample(xs[i], 1'b0, 1'b0, y, s, lat);
      total++; if (y !== er[i]) begin bad++; $display("FAIL round_dout[%0d] got=%h exp=%h", i, y, er[i]); end
      total++; if (nr_dout !== et[i]) begin bad++; $display("FAIL trunc_dout[%0d] got=%h exp=%h", i, nr_dout, et[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] y;
    logic s;
    int lat;
    for (int i = 0; i < 6; i++) write_coef(i, 16'h7FFF);
    for (int i = 0; i < 6; i++) run_sample(16'h7FFF, 1'b0, 1'b0, y, s, lat);
    total++; if (y !== 16'h7FFF) begin bad++; $display("FAIL sat_hi_dout got=%h exp=7fff", y); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL sat_hi_flag got=%b exp=1", s); end
    for (int i = 0; i < 6; i++) run_sample(16'h8000, 1'b0, 1'b0, y, s, lat);
    total++; if (y !== 16'h8000) begin bad++; $display("FAIL sat_lo_dout got=%h exp=8000", y); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL sat_lo_flag got=%b exp=1", s); end
    write_coef(0, 16'd1);
    for (int i = 1; i < 6; i++) write_coef(i, 16'd0);
    run_sample(16'h4000, 1'b0, 1'b0, y, s, lat);
    total++; if (y !== 16'h0001) begin bad++; $display("FAIL sat_clear_dout got=%h exp=0001", y); end
    total++; if (s !== 1'b0) begin bad++; $display("FAIL sat_clear_flag got=%b exp=0", s); end
  endtask

  task automatic test_handshake();
    int acc_cnt;
    int at [8];
    int g;
    acc_cnt = 0;
    nd  = 1'b1;
    din = 16'h4000;
    for (int i = 0; i < 40; i++) begin
      if (rfd) begin
        if (acc_cnt < 8) at[acc_cnt] = i;
        acc_cnt++;
      end
      @(negedge clk);
    end
    nd = 1'b0;
    total++; if (acc_cnt !== 5) begin bad++; $display("FAIL hs_accepts got=%0d exp=5", acc_cnt); end
    for (int i = 1; i < 5; i++) begin
      if (i < acc_cnt) begin
        total++;
        if (at[i] - at[i-1] !== 8) begin
          bad++;
          $display("FAIL hs_spacing[%0d] got=%0d exp=8", i, at[i] - at[i-1]);
        end
      end
    end
    g = 0;
    while (!rfd && g < 20) begin @(negedge clk); g++; end
    total++; if (dout !== 16'h0001) begin bad++; $display("FAIL hs_dout got=%h exp=0001", dout); end
  endtask

  task automatic test_drop_nd();
    logic [15:0] y;
    logic s;
    int lat;
    ctab = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600};
    load_ctab();
    flush_zero();
    for (int i = 0; i < 6; i++) begin
      run_sample((i == 0) ? 16'h7FFF : 16'h0000, (i < 2), 1'b0, y, s, lat);
      total++; if (y !== ctab[i]) begin bad++; $display("FAIL drop_dout[%0d] got=%0d exp=%0d", i, y, ctab[i]); end
    end
  endtask

  task automatic test_coef_gate();
    logic [15:0] y;
    logic s;
    int lat;
    flush_zero();
    write_coef(6, 16'h1111);
    for (int i = 0; i < 6; i++) begin
      run_sample((i == 0) ? 16'h7FFF : 16'h0000, 1'b0, 1'b1, y, s, lat);
      total++; if (y !== ctab[i]) begin bad++; $display("FAIL gate_dout[%0d] got=%0d exp=%0d", i, y, ctab[i]); end
    end
    run_sample(16'h0000, 1'b0, 1'b0, y, s, lat);
    run_sample(16'h7FFF, 1'b0, 1'b0, y, s, lat);
    total++; if (y !== 16'd100) begin bad++; $display("FAIL gate_c0 got=%0d exp=100", y); end
  endtask

  task automatic test_coincident_write();
    logic [15:0] y;
    logic s;
    int lat;
    flush_zero();
    coef_addr = 3'd0;
    coef_din  = 16'd777;
    coef_we   = 1'b1;
    run_sample(16'h7FFF, 1'b0, 1'b0, y, s, lat);
    total++; if (y !== 16'd777) begin bad++; $display("FAIL coincident_dout got=%0d exp=777", y); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] y;
    logic s;
    int lat;
    int seen;
    nd  = 1'b1;
    din = 16'h7FFF;
    @(negedge clk);
    nd = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (rfd !== 1'b1) begin bad++; $display("FAIL rmid_rfd got=%b exp=1", rfd); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rmid_rdy got=%b exp=0", rdy); end
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL rmid_dout got=%h exp=0000", dout); end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_rdy got=%0d exp=0", seen); end
    for (int i = 0; i < 6; i++) begin
      run_sample((i == 0) ? 16'h7FFF : 16'h0000, 1'b0, 1'b0, y, s, lat);
      total++; if (y !== 16'h0000) begin bad++; $display("FAIL rmid_zero[%0d] got=%h exp=0000", i, y); end
    end
    total++; if (lat !== 7) begin bad++; $display("FAIL rmid_latency got=%0d exp=7", lat); end
  endtask

  initial begin
    rst = 1'b1; nd = 1'b0; din = '0; coef_we = 1'b0; coef_addr = '0; coef_din = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_impulse();
    test_rounding();
    test_saturation();
    test_handshake();
    test_drop_nd();
    test_coef_gate();
    test_coincident_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog got=timeout exp=done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
